// File: rtl/cp0_intc_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the EPC target helper used on exception/interrupt entry.
package cp0_defs;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR field positions
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Cause field positions
  localparam int BD_BIT  = 31;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Handler state implied by SR.EXL
  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } cp0_mode_e;

  // Restart address of the victim: a delay-slot victim restarts at its branch.
  // Word aligned; PC-4 wraps modulo 2^32.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    epc_target = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_intc_req_arb.sv
// Request arbiter: decides whether the pipeline must take an interrupt or a
// synchronous exception this cycle and which ExcCode gets recorded.
// Purely combinational so the pipeline flush logic can share it.
module cp0_req_arb
  import cp0_defs::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_in,
  output logic       int_pend,
  output logic       exc_pend,
  output logic       req,
  output logic [4:0] exc_code_sel
);

  // Interrupts win over a simultaneous synchronous exception; EXL blocks both
  always_comb begin
    int_pend     = (|(hw_int & im)) & ie & ~exl;
    exc_pend     = (exc_code_in != EXC_INT) & ~exl;
    req          = int_pend | exc_pend;
    exc_code_sel = int_pend ? EXC_INT : exc_code_in;
  end

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, PRId registers,
// single take-exception request to the pipeline, eret via EXLClr.
module cp0_intc
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h4D495053,
  parameter logic [5:0]  RESET_IM = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req
);

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  // EPC, low two bits always zero
  logic [31:0] epc_q, epc_d;

  logic        arb_int_pend;
  logic        arb_exc_pend;
  logic        arb_req;
  logic [4:0]  arb_exc_code;
  logic        pend_unused;

  cp0_req_arb u_req_arb (
    .hw_int       (HWInt),
    .im           (im_q),
    .ie           (ie_q),
    .exl          (exl_q),
    .exc_code_in  (ExcCodeIn),
    .int_pend     (arb_int_pend),
    .exc_pend     (arb_exc_pend),
    .req          (arb_req),
    .exc_code_sel (arb_exc_code)
  );

  // The individual pending flags serve the pipeline flush logic, not this block
  assign pend_unused = arb_int_pend ^ arb_exc_pend;

  // Request is suppressed while reset is held, even for a pending exception code
  always_comb begin
    Req = arb_req & reset;
  end

  // Next-state: entry beats mtc0; mtc0 lands before EXLClr forces EXL low
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = HWInt;
    exc_d = exc_q;
    epc_d = epc_q;
    if (Req) begin
      exl_d = 1'b1;
      exc_d = arb_exc_code;
      bd_d  = BDIn;
      epc_d = epc_target(PC, BDIn);
    end else begin
      if (WE) begin
        case (A2)
          CP0_SR: begin
            im_d  = Din[IM_HI:IM_LO];
            exl_d = Din[EXL_BIT];
            ie_d  = Din[IE_BIT];
          end
          CP0_EPC: epc_d = Din & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // Register state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= RESET_IM;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= 6'h00;
      exc_q <= EXC_INT;
      epc_q <= 32'h0000_0000;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux; unmapped register numbers read zero
  always_comb begin
    case (A1)
      CP0_SR:    Dout = {16'h0000, im_q, 8'h00, exl_q, ie_q};
      CP0_CAUSE: Dout = {bd_q, 15'h0000, ip_q, 3'b000, exc_q, 2'b00};
      CP0_EPC:   Dout = epc_q;
      CP0_PRID:  Dout = PRID_VAL;
      default:   Dout = 32'h0000_0000;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: expected register reads are queued while
// stimulus is driven and popped against Dout when the reads are performed.
module tb_cp0_intc;

  localparam logic [31:0] PRID = 32'h4D495053;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] Dout;
  logic [31:0] EPCOut;
  logic        Req;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } rd_t;

  rd_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  cp0_intc #(
    .PRID_VAL (PRID),
    .RESET_IM (6'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .Din       (Din),
    .WE        (WE),
    .PC        (PC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .EXLClr    (EXLClr),
    .HWInt     (HWInt),
    .Dout      (Dout),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic void expect_rd(input logic [4:0] addr, input logic [31:0] exp);
    rd_t t;
    t.addr = addr;
    t.exp  = exp;
    sb_q.push_back(t);
  endfunction

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    WE = 1'b1; A2 = addr; Din = data;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic eret();
    @(negedge clk);
    EXLClr = 1'b1;
    @(negedge clk);
    EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    rd_t t;
    reset = 1'b0; HWInt = 6'h3F; ExcCodeIn = 5'd12;
    #1;
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL reset_req_in_reset: Req=%b expected 0", Req);
    end
    repeat (2) @(negedge clk);
    HWInt = 6'h00; ExcCodeIn = 5'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_rd(5'd12, 32'h0);
    expect_rd(5'd13, 32'h0);
    expect_rd(5'd14, 32'h0);
    expect_rd(5'd15, PRID);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("reset: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL reset_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    @(negedge clk);
    HWInt = 6'h3F;
    #1; checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL reset_req_ie0: Req=%b expected 0", Req);
    end
    HWInt = 6'h00;
  endtask

  task automatic test_timer_irq();
    rd_t t;
    mtc0(5'd12, 32'h0000_0401);
    PC = 32'h0000_3010; BDIn = 1'b0; HWInt = 6'h01;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL timer_req: Req=%b expected 1", Req);
    end
    @(negedge clk);
    #1; checks += 2;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL timer_req_after_entry: Req=%b expected 0", Req);
    end
    if (EPCOut !== 32'h0000_3010) begin
      errors++; $display("FAIL timer_epcout: got %h expected %h", EPCOut, 32'h0000_3010);
    end
    expect_rd(5'd14, 32'h0000_3010);
    expect_rd(5'd13, 32'h0000_0400);
    expect_rd(5'd12, 32'h0000_0403);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("timer: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL timer_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    HWInt = 6'h00;
    eret();
  endtask

  task automatic test_masked_and_bd();
    rd_t t;
    @(negedge clk);
    HWInt = 6'h02;
    #1; checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL masked_req: Req=%b expected 0", Req);
    end
    @(negedge clk);
    expect_rd(5'd13, 32'h0000_0800);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("masked: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL masked_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    HWInt = 6'h00;
    @(negedge clk);
    ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL bd_req: Req=%b expected 1", Req);
    end
    @(negedge clk);
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    expect_rd(5'd14, 32'h0000_3020);
    expect_rd(5'd13, 32'h8000_0030);
    expect_rd(5'd12, 32'h0000_0403);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("bd: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL bd_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    eret();
  endtask

  task automatic test_simultaneous();
    rd_t t;
    @(negedge clk);
    HWInt = 6'h01; ExcCodeIn = 5'd10; PC = 32'h0000_4000; BDIn = 1'b0;
    WE = 1'b1; A2 = 5'd14; Din = 32'hDEAD_BEEF;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL simul_req: Req=%b expected 1", Req);
    end
    @(negedge clk);
    WE = 1'b0; ExcCodeIn = 5'd0;
    expect_rd(5'd14, 32'h0000_4000);
    expect_rd(5'd13, 32'h0000_0400);
    expect_rd(5'd12, 32'h0000_0403);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("simul: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL simul_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
  endtask

  task automatic test_eret_reentry();
    rd_t t;
    @(negedge clk);
    #1; checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL eret_req_in_handler: Req=%b expected 0", Req);
    end
    EXLClr = 1'b1; PC = 32'h0000_5000;
    #1; checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL eret_req_before_edge: Req=%b expected 0", Req);
    end
    @(negedge clk);
    EXLClr = 1'b0;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL eret_req_after_clear: Req=%b expected 1", Req);
    end
    expect_rd(5'd14, 32'h0000_4000);
    expect_rd(5'd12, 32'h0000_0401);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("eret: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL eret_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    @(negedge clk);
    expect_rd(5'd14, 32'h0000_5000);
    expect_rd(5'd12, 32'h0000_0403);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("reentry: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL reentry_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    HWInt = 6'h00;
  endtask

  task automatic test_mtc0_paths();
    rd_t t;
    @(negedge clk);
    WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0003; EXLClr = 1'b1;
    @(negedge clk);
    WE = 1'b0; EXLClr = 1'b0;
    expect_rd(5'd12, 32'h0000_0001);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("we_eret: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL we_eret_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    mtc0(5'd14, 32'h1234_5677);
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'h0000_0000);
    expect_rd(5'd14, 32'h1234_5674);
    expect_rd(5'd13, 32'h0000_0000);
    expect_rd(5'd15, PRID);
    expect_rd(5'd3,  32'h0000_0000);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("mtc0: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL mtc0_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
  endtask

  task automatic test_pc_zero_bd();
    rd_t t;
    @(negedge clk);
    ExcCodeIn = 5'd4; BDIn = 1'b1; PC = 32'h0000_0000;
    #1; checks++;
    if (Req !== 1'b1) begin
      errors++; $display("FAIL pc0_req: Req=%b expected 1", Req);
    end
    @(negedge clk);
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    expect_rd(5'd14, 32'hFFFF_FFFC);
    expect_rd(5'd13, 32'h8000_0010);
    expect_rd(5'd12, 32'h0000_0003);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("pc0: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL pc0_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    rd_t t;
    @(negedge clk);
    HWInt = 6'h01; ExcCodeIn = 5'd5;
    #1;
    reset = 1'b0;
    expect_rd(5'd12, 32'h0);
    expect_rd(5'd13, 32'h0);
    expect_rd(5'd14, 32'h0);
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front(); A1 = t.addr; #1; checks++;
      $display("async_rst: rd r%0d = %h (exp %h)", t.addr, Dout, t.exp);
      if (Dout !== t.exp) begin
        errors++; $display("FAIL async_rst_rd r%0d: got %h expected %h", t.addr, Dout, t.exp);
      end
    end
    checks++;
    if (Req !== 1'b0) begin
      errors++; $display("FAIL async_rst_req: Req=%b expected 0", Req);
    end
    @(negedge clk);
    HWInt = 6'h00; ExcCodeIn = 5'd0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    A1 = 5'd0; A2 = 5'd0; Din = 32'h0; WE = 1'b0; PC = 32'h0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; EXLClr = 1'b0; HWInt = 6'h00;
    test_reset();
    test_timer_irq();
    test_masked_and_bd();
    test_simultaneous();
    test_eret_reentry();
    test_mtc0_paths();
    test_pc_zero_bd();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 style interrupt/exception controller for the MIPS microsystem.
- Consumes the level IRQ lines driven by bus peripherals (timer TC at HWInt[2], others above it) and holds the SR, Cause, EPC and PRId registers.
- Raises a single request to the CPU pipeline and records EPC/Cause on entry; eret (EXLClr) exits.
- Sits beside the M stage; read/written via mfc0/mtc0.

Parameters:
- PRID_VAL, 32'h4D495053, value returned by PRId (reg 15).
- RESET_IM, 6'h00, reset value of SR.IM.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- Din  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction in M stage (victim).
- BDIn  in  1  victim is in a branch delay slot.
- ExcCodeIn  in  5  synchronous exception code from pipeline; 0 = none.
- EXLClr  in  1  eret in M stage.
- HWInt  in  6  device IRQ levels, bit0 = HWInt[2] (timer).
- Dout  out  32  mfc0 read data.
- EPCOut  out  32  current EPC, for eret target.
- Req  out  1  take-exception/interrupt command to pipeline.

Behaviour:
- Register fields (all others read 0, writes ignored):
  - SR(12): IM[15:10], EXL[1], IE[0].
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC(14): [31:2], bits [1:0] read 0.
  - PRId(15): PRID_VAL.
- Reset (async, reset==0):
  - SR = {IM=RESET_IM, EXL=0, IE=0}; Cause = 0; EPC = 0.
  - Req = 0 while in reset.
- Dout: combinational read by A1. Unmapped register numbers return 0.
- IP sampling: Cause.IP <= HWInt every clock edge, unconditionally, including during EXL.
- Req (combinational), from live HWInt, not the sampled IP:
  - IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcPend = (ExcCodeIn != 0) & ~SR.EXL.
  - Req = IntPend | ExcPend.
- Entry (clock edge with Req==1):
  - EXL <= 1.
  - Cause.ExcCode <= IntPend ? 0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? PC-4 : PC, with low 2 bits cleared.
  - A same-cycle mtc0 (WE) is dropped entirely.
- Exit (clock edge with EXLClr==1 and Req==0): EXL <= 0. EPC and Cause are unchanged.
- mtc0 (WE==1, Req==0):
  - A2=12 writes IM/EXL/IE.
  - A2=14 writes EPC[31:2].
  - A2=13 and A2=15 are read-only; the write is ignored.
- WE and EXLClr in the same cycle: the mtc0 write is applied first, then EXLClr forces EXL=0, regardless of the written EXL bit.
- EXL=1 blocks nested entry. Interrupts pending during EXL raise Req one cycle after EXL clears, if still asserted.
- Latency: HWInt to Req is 0 cycles (same cycle). HWInt to Cause.IP visible on Dout is 1 cycle.
- PC-4 arithmetic: 32-bit modulo; PC=0 with BD gives 32'hFFFFFFFC.
- Reset mid-handler: EXL is cleared immediately; Req re-evaluates with IE=0, so Req=0.
- No internal FSM beyond the EXL bit. State pair: NORMAL (EXL=0), HANDLER (EXL=1).
  - NORMAL -> HANDLER on Req.
  - HANDLER -> NORMAL on EXLClr.

Decomposition:
- Shared package `cp0_defs`:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Field bit positions (IM_HI/LO, EXL, IE, BD, IP_HI/LO, EXC_HI/LO).
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- One natural sub-module: `cp0_req_arb`, combinational, computing IntPend, ExcPend, Req and the selected ExcCode. It is shared with the pipeline flush logic.

Test Plan:
1. Reset values: drop reset, read A1=12/13/14/15 -> Dout = 0, 0, 0, PRID_VAL. Req=0 with HWInt=6'h3F.
2. Timer interrupt:
   - Stimulus: mtc0 SR=32'h0000_0401; assert HWInt=6'h01 with PC=32'h0000_3010, BDIn=0.
   - Response: Req=1 the same cycle. Next cycle: EPC=32'h3010, Cause.ExcCode=0, Cause.IP=6'h01, SR.EXL=1, Req=0.
3. Masked line and delay slot:
   - Masked: SR.IM=6'h01, HWInt=6'h02 -> Req=0; Cause.IP reads 6'h02 one cycle later.
   - Delay slot: ExcCodeIn=12 with BDIn=1, PC=32'h3024 -> EPC=32'h3020, BD=1, ExcCode=12.
4. Simultaneous int + exception + mtc0:
   - Stimulus: HWInt enabled, ExcCodeIn=10, WE=1, A2=14, Din=32'hDEAD_BEEF.
   - Response: ExcCode=0 and EPC=PC; the write is dropped.
5. eret and re-entry: with EXL=1 and HWInt held, Req=0. Pulse EXLClr -> EXL=0 next edge, Req=1 that following cycle. EPC is unchanged until re-entry.
6. Async reset mid-handler: with EXL=1, pull reset low between clock edges -> SR, Cause, EPC = 0 immediately and Req=0 before the next clk edge.
